symbol_seq_gen: RTL and testbench

//  Transmit-side partner of the 2-bit symbol sequence detector. Emits a programmable
//  PAT_LEN-symbol pattern REPS times, with optional filler symbols between copies,

---
 rtl/seq_pkg.sv | 10 +
 rtl/seq_dn_counter.sv | 27 ++
 rtl/symbol_seq_gen.sv | 143 ++++++++++++++
 tb/tb_symbol_seq_gen.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the 2-bit symbol sequence generator and its detector partner.
package seq_pkg;
  localparam int SEQ_SYM_W = 2;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_GAP  = 2'd2;
  localparam state_t ST_FIN  = 2'd3;
endpackage

// File: rtl/seq_dn_counter.sv
// Loadable down-counter that saturates at zero and flags the zero state.
module seq_dn_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/symbol_seq_gen.sv
// Emits a captured PAT_LEN-symbol pattern a programmable number of times, with optional
// filler symbols between copies, over a valid/ready stream.
module symbol_seq_gen
  import seq_pkg::*;
#(
  parameter int SYM_W   = SEQ_SYM_W,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8,
  parameter int GAP_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SYM_W*PAT_LEN-1:0] pattern,
  input  logic [CNT_W-1:0]         repeat_cnt,
  input  logic [GAP_W-1:0]         gap_len,
  input  logic [SYM_W-1:0]         gap_sym,
  output logic [SYM_W-1:0]         num_out,
  output logic                     num_valid,
  input  logic                     num_ready,
  output logic                     expect_hit,
  output logic                     busy,
  output logic                     done
);
  localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_LEN - 1);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [SYM_W*PAT_LEN-1:0] pat_q, pat_d;
  logic [GAP_W-1:0]         gap_len_q, gap_len_d;
  logic [SYM_W-1:0]         gap_sym_q, gap_sym_d;
  logic [SYM_W-1:0]         num_out_q, num_out_d;
  logic                     num_valid_q, busy_q, done_q;

  logic [CNT_W-1:0] reps_cnt;
  logic [GAP_W-1:0] gcnt_cnt;
  logic             reps_zero, gcnt_zero;
  logic             reps_load, reps_dec, gcnt_load, gcnt_dec;
  logic             reps_final, gcnt_final;

  // A zero count is treated as final too, so a corrupted counter can never trap the FSM.
  assign reps_final = reps_zero || (reps_cnt == CNT_W'(1));
  assign gcnt_final = gcnt_zero || (gcnt_cnt == GAP_W'(1));

  assign expect_hit = (state_q == ST_SEND) && (idx_q == IDX_LAST) && num_ready;
  assign reps_load  = (state_q == ST_IDLE) && start;
  assign reps_dec   = expect_hit;
  assign gcnt_load  = expect_hit && !reps_final && (gap_len_q != '0);
  assign gcnt_dec   = (state_q == ST_GAP) && num_ready;

  seq_dn_counter #(.W(CNT_W)) u_reps (
    .clk        (clk),
    .reset      (reset),
    .load_i     (reps_load),
    .load_val_i (repeat_cnt),
    .dec_i      (reps_dec),
    .cnt_o      (reps_cnt),
    .zero_o     (reps_zero)
  );

  seq_dn_counter #(.W(GAP_W)) u_gcnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (gcnt_load),
    .load_val_i (gap_len_q),
    .dec_i      (gcnt_dec),
    .cnt_o      (gcnt_cnt),
    .zero_o     (gcnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pat_d     = pat_q;
    gap_len_d = gap_len_q;
    gap_sym_d = gap_sym_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d     = pattern;
          gap_len_d = gap_len;
          gap_sym_d = gap_sym;
          idx_d     = '0;
          state_d   = (repeat_cnt != '0) ? ST_SEND : ST_FIN;
        end
      end
      ST_SEND: begin
        if (num_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (reps_final)               state_d = ST_FIN;
            else if (gap_len_q == '0)     state_d = ST_SEND;
            else                          state_d = ST_GAP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (num_ready && gcnt_final) begin
          idx_d   = '0;
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are computed from next state so they are registered without a bubble.
    num_out_d = '0;
    if (state_d == ST_SEND)     num_out_d = pat_d[idx_d*SYM_W +: SYM_W];
    else if (state_d == ST_GAP) num_out_d = gap_sym_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pat_q       <= '0;
      gap_len_q   <= '0;
      gap_sym_q   <= '0;
      num_out_q   <= '0;
      num_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pat_q       <= pat_d;
      gap_len_q   <= gap_len_d;
      gap_sym_q   <= gap_sym_d;
      num_out_q   <= num_out_d;
      num_valid_q <= (state_d == ST_SEND) || (state_d == ST_GAP);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_FIN);
    end
  end

  assign num_out   = num_out_q;
  assign num_valid = num_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_symbol_seq_gen.sv
// Bench for symbol_seq_gen: directed scenarios plus randomized runs against a queue model.
module tb_symbol_seq_gen;
  localparam int SYM_W = 2, PAT_LEN = 4, CNT_W = 8, GAP_W = 4;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     start = 1'b0;
  logic [SYM_W*PAT_LEN-1:0] pattern = '0;
  logic [CNT_W-1:0]         repeat_cnt = '0;
  logic [GAP_W-1:0]         gap_len = '0;
  logic [SYM_W-1:0]         gap_sym = '0;
  logic [SYM_W-1:0]         num_out;
  logic                     num_valid;
  logic                     num_ready = 1'b0;
  logic                     expect_hit, busy, done;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [SYM_W-1:0] sym;
    logic             hit;
  } ev_t;

  symbol_seq_gen #(.SYM_W(SYM_W), .PAT_LEN(PAT_LEN), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .gap_len    (gap_len),
    .gap_sym    (gap_sym),
    .num_out    (num_out),
    .num_valid  (num_valid),
    .num_ready  (num_ready),
    .expect_hit (expect_hit),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a run and checks every cycle against the expected symbol list built from the config.
  task automatic run(input logic [7:0] pat, input logic [7:0] rc, input logic [3:0] gl,
                     input logic [1:0] gs, input int rdy_pct, input int stall_at);
    ev_t q[$];
    int  xfers = 0, total, stall_left = 3;
    bit  finished = 0;
    for (int c = 0; c < rc; c++) begin
      for (int i = 0; i < PAT_LEN; i++) q.push_back('{sym: pat[2*i +: 2], hit: (i == PAT_LEN-1)});
      if (c < rc - 1)
        for (int g = 0; g < gl; g++) q.push_back('{sym: gs, hit: 1'b0});
    end
    total = q.size();

    @(negedge clk);
    pattern = pat; repeat_cnt = rc; gap_len = gl; gap_sym = gs;
    start = 1'b1; num_ready = 1'b0;
    @(negedge clk);
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      if (q.size() > 0) begin
        if (xfers == stall_at && stall_left > 0) begin
          num_ready = 1'b0;
          stall_left--;
        end else begin
          num_ready = ($urandom_range(99) < rdy_pct);
        end
        // Inputs wiggle mid-run to show they are not resampled.
        start   = 1'($urandom_range(1));
        pattern = 8'($urandom);
        gap_sym = 2'($urandom);
        #1;
        chk("valid", num_valid, 1);
        chk("sym", num_out, q[0].sym);
        chk("hit", expect_hit, num_ready && q[0].hit);
        chk("busy", busy, 1);
        chk("done_early", done, 0);
        if (num_ready) begin
          void'(q.pop_front());
          xfers++;
        end
        @(negedge clk);
      end else begin
        start = 1'b0;
        num_ready = 1'($urandom_range(1));
        #1;
        chk("fin_valid", num_valid, 0);
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 1);
        chk("fin_hit", expect_hit, 0);
        @(negedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_valid", num_valid, 0);
        finished = 1;
      end
    end
    if (!finished) begin
      chk("timeout", 0, 1);
      start = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
    chk("xfers", xfers, total);
  endtask

  initial begin
    num_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", num_valid, 0);
    chk("rst_out", num_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hit", expect_hit, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single copy, full throughput: 1,2,1,3 then done.
    run(8'b11_01_10_01, 8'd1, 4'd0, 2'd0, 100, -1);
    // Two copies with two filler zeros.
    run(8'b11_01_10_01, 8'd2, 4'd2, 2'd0, 100, -1);
    // Backpressure on the second symbol.
    run(8'b11_01_10_01, 8'd1, 4'd0, 2'd0, 100, 1);
    // Zero repeats: straight to FIN.
    run(8'b11_01_10_01, 8'd0, 4'd3, 2'd2, 100, -1);
    // Back-to-back copies.
    run(8'b00_11_10_01, 8'd3, 4'd0, 2'd0, 100, -1);

    // Asynchronous reset while filler symbols are being sent.
    @(negedge clk);
    pattern = 8'b01_10_11_00; repeat_cnt = 8'd2; gap_len = 4'd3; gap_sym = 2'd3;
    start = 1'b1; num_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("gap_valid", num_valid, 1);
    chk("gap_sym", num_out, 3);
    chk("gap_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("arst_valid", num_valid, 0);
    chk("arst_out", num_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_hit", expect_hit, 0);
    @(negedge clk);
    reset = 1'b0;
    run(8'b10_00_01_11, 8'd1, 4'd1, 2'd1, 100, -1);

    // Randomized configs and ready patterns.
    for (int r = 0; r < 25; r++)
      run(8'($urandom), 8'($urandom_range(5)), 4'($urandom_range(3)), 2'($urandom),
          $urandom_range(100, 30), (r % 4 == 0) ? int'($urandom_range(6)) : -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
